// File: rtl/channel_to_pixel_pkg.sv
// Shared widths and state encoding for channel_to_pixel and its divider.
// VGA_VER_RES mirrors the shared VGA header value.
package channel_to_pixel_pkg;

   localparam int VGA_VER_RES        = 480;
   localparam int RW                 = $clog2(VGA_VER_RES);
   localparam int MAX_CHAN_COUNT_DEF = 10;

   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CW = chan_w(MAX_CHAN_COUNT_DEF);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_DIV  = 3'd1;
   localparam logic [2:0] ST_MUL  = 3'd2;
   localparam logic [2:0] ST_CALC = 3'd3;
   localparam logic [2:0] ST_RESP = 3'd4;

endpackage

// File: rtl/channel_to_pixel_seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first (W >= 2).
// Latency: W cycles after start; done flags the cycle that computes the last bit.
// Backpressure: none; quotient holds after the last bit until the next start.
module seq_divider #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CNTW = $clog2(W + 1);

   logic            busy;
   logic [CNTW-1:0] cnt;
   logic [W-1:0]    dvsr;
   logic [W-1:0]    rem;
   logic [W:0]      trial;
   logic            ge;

   // The dividend is shifted out of the quotient register as quotient bits shift in.
   assign trial = {rem, quotient[W-1]};
   assign ge    = (trial >= {1'b0, dvsr});
   assign done  = busy && (cnt == CNTW'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy     <= 1'b0;
         cnt      <= '0;
         dvsr     <= '0;
         rem      <= '0;
         quotient <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= CNTW'(W);
         dvsr     <= divisor;
         rem      <= '0;
         quotient <= dividend;
      end else if (busy) begin
         rem      <= ge ? W'(trial - {1'b0, dvsr}) : trial[W-1:0];
         quotient <= {quotient[W-2:0], ge};
         cnt      <= cnt - CNTW'(1);
         if (cnt == CNTW'(1)) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/channel_to_pixel.sv
// Channel + sample -> band offset/height and screen row. Option macro: CHANNEL_TO_PIXEL_GAP_EN.
// Latency: miss 1 cycle, hit RW+SAMPLE_WIDTH+2 cycles after accept; one request in flight.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module channel_to_pixel
   import channel_to_pixel_pkg::*;
#(
   parameter int MAX_CHAN_COUNT = MAX_CHAN_COUNT_DEF,
   parameter int OFFSET         = 0,
   parameter int SAMPLE_WIDTH   = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [MAX_CHAN_COUNT-1:0]         channel_enable,
   input  logic                              req_valid,
   output logic                              req_ready,
   input  logic [chan_w(MAX_CHAN_COUNT)-1:0] req_channel,
   input  logic [SAMPLE_WIDTH-1:0]           req_sample,
   output logic                              rsp_valid,
   input  logic                              rsp_ready,
   output logic                              rsp_hit,
   output logic [RW-1:0]                     rsp_row,
   output logic [RW-1:0]                     rsp_offset,
   output logic [RW-1:0]                     rsp_height
);

   localparam int CH_W = chan_w(MAX_CHAN_COUNT);
   localparam int NW   = $clog2(MAX_CHAN_COUNT + 1);
   localparam int SW   = SAMPLE_WIDTH;
   localparam int PW   = SW + RW;
   localparam int MW   = (SW > 1) ? $clog2(SW) : 1;

   if (((VGA_VER_RES - OFFSET) / MAX_CHAN_COUNT) < 2) begin : g_height_chk
      $error("channel_to_pixel: band height below 2 rows for MAX_CHAN_COUNT channels");
   end

   logic [2:0]    state;
   logic [NW-1:0] cnt_c, vis_c, vis_q;
   logic          chan_en_c, hit_c, accept;
   logic          div_done;
   logic [RW-1:0] height, dh, off_c, row_c;
   logic [SW-1:0] sample_sh;
   logic [PW-1:0] acc;
   logic [MW-1:0] mcnt;

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign accept    = req_ready && req_valid;

   always_comb begin
      cnt_c     = '0;
      vis_c     = '0;
      chan_en_c = 1'b0;
      for (int i = 0; i < MAX_CHAN_COUNT; i++) begin
         if (channel_enable[i]) begin
            cnt_c = cnt_c + NW'(1);
            if (CH_W'(i) < req_channel) vis_c = vis_c + NW'(1);
            if (CH_W'(i) == req_channel) chan_en_c = 1'b1;
         end
      end
      hit_c = chan_en_c && (cnt_c != '0);
   end

   seq_divider #(.W(RW)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept && hit_c),
      .dividend (RW'(VGA_VER_RES - OFFSET)),
      .divisor  ({{(RW-NW){1'b0}}, cnt_c}),
      .done     (div_done),
      .quotient (height)
   );

`ifdef CHANNEL_TO_PIXEL_GAP_EN
   assign dh = height - RW'(1);
`else
   assign dh = height;
`endif

   // acc[PW-1:SW] is the scaled sample, always below dh, so the row stays inside the band.
   assign off_c = RW'(OFFSET) + height * {{(RW-NW){1'b0}}, vis_q};
   assign row_c = off_c + dh - RW'(1) - acc[PW-1:SW];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         rsp_hit    <= 1'b0;
         rsp_row    <= '0;
         rsp_offset <= '0;
         rsp_height <= '0;
         vis_q      <= '0;
         sample_sh  <= '0;
         acc        <= '0;
         mcnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  rsp_hit    <= 1'b0;
                  rsp_row    <= '0;
                  rsp_offset <= '0;
                  rsp_height <= '0;
                  vis_q      <= vis_c;
                  sample_sh  <= req_sample;
                  acc        <= '0;
                  mcnt       <= MW'(SW - 1);
                  state      <= hit_c ? ST_DIV : ST_RESP;
               end
            end
            ST_DIV: begin
               if (div_done) state <= ST_MUL;
            end
            ST_MUL: begin
               // MSB-first shift-add: acc = acc*2 + bit*dh.
               acc       <= {acc[PW-2:0], 1'b0} + (sample_sh[SW-1] ? PW'(dh) : '0);
               sample_sh <= sample_sh << 1;
               if (mcnt == '0) state <= ST_CALC;
               else            mcnt  <= mcnt - MW'(1);
            end
            ST_CALC: begin
               rsp_hit    <= 1'b1;
               rsp_row    <= row_c;
               rsp_offset <= off_c;
               rsp_height <= height;
               state      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_channel_to_pixel.sv
// Directed bench for channel_to_pixel at 480 rows / 10 channels / 8-bit samples.
module tb_channel_to_pixel;
   import channel_to_pixel_pkg::*;

`ifdef CHANNEL_TO_PIXEL_GAP_EN
   localparam int GAP = 1;
`else
   localparam int GAP = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [9:0]    channel_enable = '0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [CW-1:0] req_channel = '0;
   logic [7:0]    req_sample = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic          rsp_hit;
   logic [RW-1:0] rsp_row, rsp_offset, rsp_height;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   channel_to_pixel #(.MAX_CHAN_COUNT(10), .OFFSET(0), .SAMPLE_WIDTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .channel_enable (channel_enable),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_channel    (req_channel),
      .req_sample     (req_sample),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_hit        (rsp_hit),
      .rsp_row        (rsp_row),
      .rsp_offset     (rsp_offset),
      .rsp_height     (rsp_height)
   );

   typedef struct {
      logic [9:0] en;
      int         ch;
      int         smp;
      int         hit;
      int         row;
      int         off;
      int         hgt;
      int         lat;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called #1 after an edge; returns #1 after the accepting edge with inputs scrambled.
   task automatic issue(input logic [9:0] en, input int ch, input int smp);
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) chk("req_ready_timeout", 0, 1);
      channel_enable = en;
      req_channel    = CW'(ch);
      req_sample     = 8'(smp);
      req_valid      = 1'b1;
      @(posedge clk); #1;
      req_valid      = 1'b0;
      channel_enable = ~en;
      req_channel    = CW'(3);
      req_sample     = ~req_sample;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_rsp(input string tag, input vec_t v, input int lat);
      chk({tag, "_latency"}, lat, v.lat);
      chk({tag, "_hit"}, int'(rsp_hit), v.hit);
      chk({tag, "_row"}, int'(rsp_row), v.row);
      chk({tag, "_offset"}, int'(rsp_offset), v.off);
      chk({tag, "_height"}, int'(rsp_height), v.hgt);
   endtask

   initial begin
      int lat;
      vecs[0]  = '{10'b0000000001, 0, 0,   1, GAP ? 478 : 479, 0,   480, 19};
      vecs[1]  = '{10'b0000100101, 5, 255, 1, 320,             320, 160, 19};
      vecs[2]  = '{10'b0000100101, 1, 77,  0, 0,               0,   0,   1};
      vecs[3]  = '{10'b0000000000, 0, 10,  0, 0,               0,   0,   1};
      vecs[4]  = '{10'b0000100101, 12, 200, 0, 0,              0,   0,   1};
      vecs[5]  = '{10'b0000100101, 5, 0,   1, GAP ? 478 : 479, 320, 160, 19};
      vecs[6]  = '{10'b1111111111, 9, 128, 1, 455,             432, 48,  19};
      vecs[7]  = '{10'b1000000000, 9, 1,   1, GAP ? 477 : 478, 0,   480, 19};
      vecs[8]  = '{10'b0000000011, 1, 200, 1, 292,             240, 240, 19};
      vecs[9]  = '{10'b0000100101, 0, 128, 1, 79,              0,   160, 19};
      vecs[10] = '{10'b1111111111, 0, 255, 1, 0,               0,   48,  19};

      repeat (3) @(posedge clk);
      #1;
      chk("reset_req_ready", int'(req_ready), 1);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_rsp_hit", int'(rsp_hit), 0);
      chk("reset_rsp_row", int'(rsp_row), 0);
      chk("reset_rsp_offset", int'(rsp_offset), 0);
      chk("reset_rsp_height", int'(rsp_height), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].en, vecs[i].ch, vecs[i].smp);
         wait_rsp(lat);
         check_rsp($sformatf("vec%0d", i), vecs[i], lat);
         chk($sformatf("vec%0d_req_ready_in_resp", i), int'(req_ready), 0);
         @(posedge clk); #1;
         chk($sformatf("vec%0d_rsp_valid_drop", i), int'(rsp_valid), 0);
      end

      // Response held under backpressure.
      rsp_ready = 1'b0;
      issue(vecs[1].en, vecs[1].ch, vecs[1].smp);
      wait_rsp(lat);
      check_rsp("hold", vecs[1], lat);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk($sformatf("hold%0d_rsp_valid", k), int'(rsp_valid), 1);
         chk($sformatf("hold%0d_req_ready", k), int'(req_ready), 0);
         chk($sformatf("hold%0d_row", k), int'(rsp_row), 320);
         chk($sformatf("hold%0d_offset", k), int'(rsp_offset), 320);
         chk($sformatf("hold%0d_height", k), int'(rsp_height), 160);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("hold_release_rsp_valid", int'(rsp_valid), 0);
      chk("hold_release_req_ready", int'(req_ready), 1);

      // Reset in the middle of the division.
      issue(vecs[1].en, vecs[1].ch, vecs[1].smp);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_div_busy", int'(req_ready), 0);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mid_reset_req_ready", int'(req_ready), 1);
      chk("mid_reset_rsp_valid", int'(rsp_valid), 0);
      chk("mid_reset_rsp_hit", int'(rsp_hit), 0);
      issue(vecs[1].en, vecs[1].ch, vecs[1].smp);
      wait_rsp(lat);
      check_rsp("after_reset", vecs[1], lat);
      @(posedge clk); #1;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
